fifo_drain_arbiter: RTL and testbench

- Read-side scheduler that shares one output stream among `NUM_CH` asynchronous FIFOs in the acquisition path.
- Selects a non-empty channel round-robin and pops a burst of up to `BURST_LEN` words from it through the FIFO's `rdreq`/`rdempty`/`q` port.
- Tags each word with its channel number and hands it to the host-link packer through a valid/ready handshake.
- Runs entirely in the FIFO read clock domain.

---
 rtl/fifo_drain_pkg.sv | 13 +
 rtl/drain_out_buf.sv | 50 +++++
 rtl/fifo_drain_arbiter.sv | 152 +++++++++++++++
 tb/tb_fifo_drain_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO drain arbiter.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } drain_state_e;

  localparam int BUF_DEPTH = 4;
  localparam int BUF_CNTW  = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/drain_out_buf.sv
// Small synchronous output FIFO; the head entry drives the stream outputs
// directly from registers.
module drain_out_buf
  import fifo_drain_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                rdclk,
  input  logic                PresetFull,
  input  logic                push_i,
  input  logic [W-1:0]        push_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [W-1:0]        out_data_o,
  output logic [BUF_CNTW-1:0] count_o
);

  localparam int PW = $clog2(BUF_DEPTH);

  logic [W-1:0]        mem_q [BUF_DEPTH];
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [BUF_CNTW-1:0] count_q;
  logic                push_ok;
  logic                pop;

  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign push_ok     = push_i & (count_q != BUF_CNTW'(BUF_DEPTH));
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  always_ff @(posedge rdclk or posedge PresetFull) begin
    if (PresetFull) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_ok && !pop)      count_q <= count_q + BUF_CNTW'(1);
      else if (!push_ok && pop) count_q <= count_q - BUF_CNTW'(1);
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin burst reader that drains several async FIFOs into one
// channel-tagged valid/ready stream, all in the read clock domain.
//
// state    | meaning
// ST_IDLE  | looking for an enabled, non-empty channel after rr_ptr
// ST_BURST | popping up to BURST_LEN words from the granted channel
// ST_FLUSH | waiting for the last popped word to land, then report
module fifo_drain_arbiter
  import fifo_drain_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16,
  parameter int CHW        = $clog2(NUM_CH),
  parameter int CNTW       = $clog2(BURST_LEN + 1)
) (
  input  logic                         rdclk,
  input  logic                         PresetFull,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH-1:0]            rdempty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] q,
  output logic [NUM_CH-1:0]            rdreq,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CHW-1:0]               out_ch,
  output logic                         out_sop,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         burst_done,
  output logic [CNTW-1:0]              burst_words
);

  localparam int BW = DATA_WIDTH + CHW + 1;

  drain_state_e        state_q, state_d;
  logic [CHW-1:0]      g_q, g_d;
  logic [CHW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                first_q, first_d;
  logic                pend_q, pend_d;
  logic                done_q, done_d;
  logic [CNTW-1:0]     words_q, words_d;

  logic                found;
  logic [CHW-1:0]      grant;
  logic                pop;
  logic                credit_ok;
  logic [BUF_CNTW-1:0] buf_count;
  logic [BW-1:0]       push_data;
  logic [BW-1:0]       head_data;

  // Keeps room for one in-flight word plus the one a new pop would add.
  assign credit_ok = (int'(buf_count) + int'(pend_q)) <= (BUF_DEPTH - 2);

  always_comb begin
    int idx;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_CH;
      if (!found && ch_en[idx] && !rdempty[idx]) begin
        found = 1'b1;
        grant = CHW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    done_d   = 1'b0;
    words_d  = words_q;
    rdreq    = '0;
    pop      = 1'b0;

    if (pend_q) first_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_BURST;
          g_d     = grant;
          cnt_d   = '0;
          first_d = 1'b1;
        end
      end
      ST_BURST: begin
        if (ch_en[g_q] && !rdempty[g_q] && credit_ok && (int'(cnt_q) < BURST_LEN)) begin
          rdreq[g_q] = 1'b1;
          pop        = 1'b1;
          cnt_d      = cnt_q + CNTW'(1);
        end
        if ((pop && (int'(cnt_q) + 1 == BURST_LEN)) || rdempty[g_q] || !ch_en[g_q])
          state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!pend_q) begin
          done_d   = 1'b1;
          words_d  = cnt_q;
          rr_ptr_d = g_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pend_d = pop;
  end

  always_ff @(posedge rdclk or posedge PresetFull) begin
    if (PresetFull) begin
      state_q  <= ST_IDLE;
      g_q      <= '0;
      rr_ptr_q <= CHW'(NUM_CH - 1);
      cnt_q    <= '0;
      first_q  <= 1'b0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      words_q  <= words_d;
    end
  end

  assign push_data = {q[int'(g_q)*DATA_WIDTH +: DATA_WIDTH], g_q, first_q};

  drain_out_buf #(.W(BW)) u_buf (
    .rdclk       (rdclk),
    .PresetFull  (PresetFull),
    .push_i      (pend_q),
    .push_data_i (push_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (head_data),
    .count_o     (buf_count)
  );

  assign {out_data, out_ch, out_sop} = head_data;
  assign burst_done  = done_q;
  assign burst_words = words_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench: behavioural FIFOs feed the arbiter, a monitor checks stream order.
module tb_fifo_drain_arbiter;

  logic        rdclk = 1'b0;
  logic        PresetFull;
  logic [3:0]  ch_en;
  logic [3:0]  rdempty;
  logic [31:0] q;
  logic [3:0]  rdreq;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_sop, out_valid, out_ready, burst_done;
  logic [4:0]  burst_words;

  always #5 rdclk = ~rdclk;

  fifo_drain_arbiter #(.NUM_CH(4), .DATA_WIDTH(8), .BURST_LEN(16)) dut (
    .rdclk(rdclk), .PresetFull(PresetFull), .ch_en(ch_en), .rdempty(rdempty), .q(q),
    .rdreq(rdreq), .out_data(out_data), .out_ch(out_ch), .out_sop(out_sop),
    .out_valid(out_valid), .out_ready(out_ready), .burst_done(burst_done),
    .burst_words(burst_words)
  );

  function automatic logic [7:0] mkword(input int c, input int i);
    return 8'(((c % 4) * 64) + (i % 64));
  endfunction

  // Behavioural FIFOs: written by the stimulus, read by the DUT.
  int wr_tot [4] = '{0, 0, 0, 0};
  int rd_tot [4] = '{0, 0, 0, 0};

  always_comb
    for (int c = 0; c < 4; c++) rdempty[c] = !(wr_tot[c] > rd_tot[c]);

  always @(posedge rdclk)
    for (int c = 0; c < 4; c++)
      if (rdreq[c] && (wr_tot[c] > rd_tot[c])) begin
        q[c*8 +: 8] <= mkword(c, rd_tot[c]);
        rd_tot[c]   <= rd_tot[c] + 1;
      end

  int n_words = 0, n_sop = 0, n_done = 0, sum_done = 0, seq_err = 0, hot_err = 0;
  int sop_log [256];
  int done_log [256];
  int exp_idx [4] = '{0, 0, 0, 0};

  always @(negedge rdclk) begin
    if ($countones(rdreq) > 1) hot_err++;
    if (PresetFull) begin
      for (int c = 0; c < 4; c++) exp_idx[c] = rd_tot[c];
    end else begin
      if (out_valid && out_ready) begin
        if (out_data != mkword(int'(out_ch), exp_idx[out_ch])) seq_err++;
        exp_idx[out_ch]++;
        n_words++;
        if (out_sop) begin
          sop_log[n_sop % 256] = int'(out_ch);
          n_sop++;
        end
      end
      if (burst_done) begin
        done_log[n_done % 256] = int'(burst_words);
        n_done++;
        sum_done += int'(burst_words);
      end
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge rdclk);
      #1;
    end
  endtask

  task automatic load(input int c, input int n);
    wr_tot[c] = wr_tot[c] + n;
  endtask

  task automatic do_reset();
    PresetFull = 1'b1;
    tick(1);
    PresetFull = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input string name, input int max);
    int quiet = 0;
    int t = 0;
    while (quiet < 8 && t < max) begin
      tick(1);
      t++;
      if (rdreq == 4'b0 && !out_valid && !burst_done) quiet++;
      else quiet = 0;
    end
    check({name, "_idle"}, quiet, 8);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdreq"}, int'(rdreq), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_data"}, int'(out_data), 0);
    check({tag, "_ch"}, int'(out_ch), 0);
    check({tag, "_sop"}, int'(out_sop), 0);
    check({tag, "_done"}, int'(burst_done), 0);
    check({tag, "_words"}, int'(burst_words), 0);
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] en;
    int         l0, l1, l2, l3;
    int         words, sops, dones, sum, first_ch, last_ch;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int w0, s0, d0, sm0, r0, popped, t, inflight, r_mid;
    // {rst, en, load0..3, words, sops, dones, sum_words, first_ch, last_ch}
    tbl[0] = '{1'b0, 4'hF,  1,  0,  1,  0,   2,  2,  2,   2, 2, 0};
    tbl[1] = '{1'b1, 4'hF, 40, 40, 40, 40, 160, 12, 12, 160, 0, 3};
    tbl[2] = '{1'b0, 4'hD,  5,  5,  5,  5,  15,  3,  3,  15, 0, 3};
    tbl[3] = '{1'b0, 4'hF,  0,  0,  0,  0,   5,  1,  1,   5, 1, 1};

    PresetFull = 1'b1;
    ch_en      = 4'hF;
    out_ready  = 1'b1;
    #1;
    check_reset_outputs("por");
    tick(2);
    PresetFull = 1'b0;
    tick(1);

    // First-word latency: ch0 with three words.
    w0 = n_words;
    load(0, 3);
    tick(1);
    check("lat_rdreq_e0", int'(rdreq), 1);
    check("lat_valid_e0", int'(out_valid), 0);
    tick(1);
    check("lat_valid_e1", int'(out_valid), 0);
    tick(1);
    check("lat_valid_e2", int'(out_valid), 1);
    check("lat_data_e2", int'(out_data), int'(mkword(0, 0)));
    check("lat_sop_e2", int'(out_sop), 1);
    check("lat_ch_e2", int'(out_ch), 0);
    tick(3);
    check("lat_done", int'(burst_done), 1);
    check("lat_words", int'(burst_words), 3);
    check("lat_valid_end", int'(out_valid), 0);
    wait_idle("lat", 200);
    check("lat_total", n_words - w0, 3);

    for (int v = 0; v < 4; v++) begin
      if (tbl[v].rst) do_reset();
      ch_en = tbl[v].en;
      w0 = n_words; s0 = n_sop; d0 = n_done; sm0 = sum_done;
      load(0, tbl[v].l0); load(1, tbl[v].l1); load(2, tbl[v].l2); load(3, tbl[v].l3);
      wait_idle($sformatf("v%0d", v), 2000);
      check($sformatf("v%0d_words", v), n_words - w0, tbl[v].words);
      check($sformatf("v%0d_sops", v), n_sop - s0, tbl[v].sops);
      check($sformatf("v%0d_dones", v), n_done - d0, tbl[v].dones);
      check($sformatf("v%0d_sum", v), sum_done - sm0, tbl[v].sum);
      check($sformatf("v%0d_first_ch", v), sop_log[s0 % 256], tbl[v].first_ch);
      check($sformatf("v%0d_last_ch", v), sop_log[(n_sop + 255) % 256], tbl[v].last_ch);
      if (v == 2) check("dis_ch1_left", wr_tot[1] - rd_tot[1], 5);
    end

    // Sink stall mid-burst on ch2.
    ch_en = 4'hF;
    w0 = n_words; r0 = rd_tot[2];
    load(2, 10);
    t = 0;
    while (!out_valid && t < 20) begin tick(1); t++; end
    check("stall_start_valid", int'(out_valid), 1);
    out_ready = 1'b0;
    tick(10);
    r_mid = rd_tot[2];
    tick(10);
    check("stall_rdreq_off", int'(rdreq), 0);
    check("stall_no_more_pops", rd_tot[2], r_mid);
    inflight = (rd_tot[2] - r0) - (n_words - w0);
    check("stall_inflight_le_depth", int'(inflight <= 4), 1);
    check("stall_valid_held", int'(out_valid), 1);
    out_ready = 1'b1;
    wait_idle("stall", 500);
    check("stall_total", n_words - w0, 10);

    // ch3 empties after 5 pops and is refilled; it must wait behind ch0 and ch1.
    s0 = n_sop; d0 = n_done;
    load(3, 5); load(0, 3); load(1, 3);
    t = 0;
    while (!burst_done && t < 100) begin tick(1); t++; end
    check("empty_done_seen", int'(burst_done), 1);
    check("empty_done_words", int'(burst_words), 5);
    load(3, 2);
    wait_idle("empty", 500);
    check("empty_b0", done_log[d0 % 256], 5);
    check("empty_b1", done_log[(d0 + 1) % 256], 3);
    check("empty_b2", done_log[(d0 + 2) % 256], 3);
    check("empty_b3", done_log[(d0 + 3) % 256], 2);
    check("empty_g0", sop_log[s0 % 256], 3);
    check("empty_g1", sop_log[(s0 + 1) % 256], 0);
    check("empty_g2", sop_log[(s0 + 2) % 256], 1);
    check("empty_g3", sop_log[(s0 + 3) % 256], 3);

    // Drop ch_en on the granted channel mid-burst.
    w0 = n_words; r0 = rd_tot[0];
    load(0, 10);
    t = 0;
    while ((rd_tot[0] - r0) < 3 && t < 50) begin tick(1); t++; end
    ch_en = 4'b1110;
    #1;
    check("dis_rdreq_off", int'(rdreq), 0);
    popped = rd_tot[0] - r0;
    t = 0;
    while (!burst_done && t < 4) begin tick(1); t++; end
    check("dis_done_seen", int'(burst_done), 1);
    check("dis_done_words", int'(burst_words), popped);
    check("dis_no_more_pops", rd_tot[0] - r0, popped);
    ch_en = 4'hF;
    wait_idle("dis", 500);
    check("dis_total", n_words - w0, 10);

    // Reset in the middle of a ch1 burst.
    w0 = n_words;
    load(1, 10);
    t = 0;
    while ((n_words - w0) < 2 && t < 50) begin tick(1); t++; end
    s0 = n_sop;
    PresetFull = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick(1);
    PresetFull = 1'b0;
    r0 = rd_tot[1];
    w0 = n_words;
    load(0, 2);
    wait_idle("midrst", 500);
    check("midrst_first_ch", sop_log[s0 % 256], 0);
    check("midrst_total", n_words - w0, 2 + (wr_tot[1] - r0));

    check("stream_order_errors", seq_err, 0);
    check("rdreq_onehot_errors", hot_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
